// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Multi-cycle controller for a 16-bit accumulator-free RISC datapath. Fetches
// one instruction per pass from a combinational instruction memory, decodes
// it into register addresses / immediate / ALU select, and sequences the
// datapath write enables through FETCH -> DECODE -> EXECUTE (-> MEM -> WB for
// loads). Branches are resolved in EXECUTE from the live datapath flags.
//
// Optional build macro:
//   CONTROL_STEP_EN  - adds input `step`; FETCH only advances on a rising
//                      edge that samples step = 1 (single-step debug).
//
// Ports:
//   clock       in   1   system clock, rising edge
//   reset       in   1   asynchronous, active-high reset
//   step        in   1   single-step enable (CONTROL_STEP_EN builds only)
//   instr_addr  out  8   instruction memory address (= pc)
//   instr_data  in  16   instruction word read at instr_addr
//   zero_flag   in   1   datapath: alu_out == 0
//   pos_flag    in   1   datapath: alu_out[15] == 0
//   rf_write    out  1   register file write enable
//   rs_addr     out  3   source register A
//   rt_addr     out  3   source register B
//   rd_addr     out  3   destination register
//   imm_data    out 16   immediate for ALU in1
//   alu_sel     out  4   ALU operation
//   imm_sel     out  1   1 = ALU in1 takes imm_data
//   mem_write   out  1   data memory write enable
//   mem_sel     out  1   1 = register file data comes from memory
//   halted      out  1   processor stopped
//   illegal_op  out  1   sticky: an undefined opcode was fetched
// ---------------------------------------------------------------------------
module control_unit #(
  parameter logic [3:0] ALU_ADD   = 4'h0,
  parameter logic [3:0] ALU_SUB   = 4'h1,
  parameter logic [3:0] ALU_PASSB = 4'h8
) (
  input  logic        clock,
  input  logic        reset,
`ifdef CONTROL_STEP_EN
  input  logic        step,
`endif
  output logic [7:0]  instr_addr,
  input  logic [15:0] instr_data,
  input  logic        zero_flag,
  input  logic        pos_flag,
  output logic        rf_write,
  output logic [2:0]  rs_addr,
  output logic [2:0]  rt_addr,
  output logic [2:0]  rd_addr,
  output logic [15:0] imm_data,
  output logic [3:0]  alu_sel,
  output logic        imm_sel,
  output logic        mem_write,
  output logic        mem_sel,
  output logic        halted,
  output logic        illegal_op
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_BZ   = 4'h5;
  localparam logic [3:0] OP_BP   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_pc;
  logic [15:0]        r_ir;
  logic               r_illegal;

  logic [3:0]         w_op;
  logic               w_fetch_go;
  logic               w_br_taken;
  logic signed [7:0]  w_br_off;

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'h9) && (op <= 4'hE);
  endfunction

  assign w_op = r_ir[15:12];

`ifdef CONTROL_STEP_EN
  assign w_fetch_go = step;
`else
  assign w_fetch_go = 1'b1;
`endif

  // BZ/BP carry a 9-bit offset; only its low 8 bits matter for 8-bit
  // modulo pc arithmetic. BEQ carries a 6-bit offset that is sign-extended.
  assign w_br_off   = (w_op == OP_BEQ) ? $signed({{2{r_ir[5]}}, r_ir[5:0]})
                                       : $signed(r_ir[7:0]);
  assign w_br_taken = ((w_op == OP_BZ)  && zero_flag) ||
                      ((w_op == OP_BP)  && pos_flag)  ||
                      ((w_op == OP_BEQ) && zero_flag);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // pc / IR / sticky illegal flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc      <= 8'h00;
      r_ir      <= 16'h0000;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_fetch_go) begin
            r_ir <= instr_data;
            r_pc <= r_pc + 8'd1;
            if (is_illegal(instr_data[15:12])) begin
              r_illegal <= 1'b1;
            end
          end
        end
        S_EXECUTE: begin
          // pc already points past this instruction, so the offset is
          // relative to the following instruction.
          if (w_op == OP_JMP) begin
            r_pc <= r_ir[7:0];
          end else if (w_br_taken) begin
            r_pc <= r_pc + $unsigned(w_br_off);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:   w_state_nxt = w_fetch_go ? S_DECODE : S_FETCH;
      S_DECODE:  w_state_nxt = S_EXECUTE;
      S_EXECUTE: begin
        if (w_op == OP_LD) begin
          w_state_nxt = S_MEM;
        end else if (w_op == OP_HALT) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_MEM:     w_state_nxt = S_WB;
      S_WB:      w_state_nxt = S_FETCH;
      S_HALT:    w_state_nxt = S_HALT;
      default:   w_state_nxt = S_FETCH;
    endcase
  end

  // Moore outputs: decoded fields are only presented while an instruction is
  // in flight, so FETCH and HALT (and the reset state) drive all zeros.
  assign instr_addr = r_pc;
  assign illegal_op = r_illegal;

  always_comb begin
    rf_write  = 1'b0;
    mem_write = 1'b0;
    mem_sel   = 1'b0;
    imm_sel   = 1'b0;
    rs_addr   = 3'd0;
    rt_addr   = 3'd0;
    rd_addr   = 3'd0;
    imm_data  = 16'h0000;
    alu_sel   = 4'h0;
    halted    = (r_state == S_HALT);

    if (r_state inside {S_DECODE, S_EXECUTE, S_MEM, S_WB}) begin
      case (w_op)
        OP_ALU: begin
          rd_addr = r_ir[11:9];
          rs_addr = r_ir[8:6];
          rt_addr = r_ir[5:3];
          alu_sel = {1'b0, r_ir[2:0]};
        end
        OP_ADDI, OP_LD: begin
          rd_addr  = r_ir[11:9];
          rs_addr  = r_ir[8:6];
          imm_data = sext6(r_ir[5:0]);
          alu_sel  = ALU_ADD;
          imm_sel  = 1'b1;
        end
        OP_ST: begin
          // ALU passes the 5-bit address through; rs supplies store data.
          rs_addr  = r_ir[8:6];
          imm_data = {11'd0, r_ir[4:0]};
          alu_sel  = ALU_PASSB;
          imm_sel  = 1'b1;
        end
        OP_BZ, OP_BP: begin
          // rs + 0 exposes rs on the flags.
          rs_addr = r_ir[11:9];
          alu_sel = ALU_ADD;
          imm_sel = 1'b1;
        end
        OP_BEQ: begin
          rs_addr = r_ir[11:9];
          rt_addr = r_ir[8:6];
          alu_sel = ALU_SUB;
        end
        default: ;
      endcase

      if (r_state == S_EXECUTE) begin
        rf_write  = (w_op == OP_ALU) || (w_op == OP_ADDI);
        mem_write = (w_op == OP_ST);
      end
      // WB is only reachable through a load.
      if (r_state == S_WB) begin
        rf_write = 1'b1;
        mem_sel  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  typedef logic [42:0] obs_t;

  logic        clock;
  logic        reset;
`ifdef CONTROL_STEP_EN
  logic        step;
`endif
  logic [7:0]  instr_addr;
  logic [15:0] instr_data;
  logic        zero_flag;
  logic        pos_flag;
  logic        rf_write;
  logic [2:0]  rs_addr, rt_addr, rd_addr;
  logic [15:0] imm_data;
  logic [3:0]  alu_sel;
  logic        imm_sel, mem_write, mem_sel, halted, illegal_op;

  logic [15:0] imem [256];
  obs_t        sb [$];
  int          vectors = 0;
  int          miscompares = 0;

  assign instr_data = imem[instr_addr];

  control_unit dut (
    .clock      (clock),
    .reset      (reset),
`ifdef CONTROL_STEP_EN
    .step       (step),
`endif
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .zero_flag  (zero_flag),
    .pos_flag   (pos_flag),
    .rf_write   (rf_write),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rd_addr    (rd_addr),
    .imm_data   (imm_data),
    .alu_sel    (alu_sel),
    .imm_sel    (imm_sel),
    .mem_write  (mem_write),
    .mem_sel    (mem_sel),
    .halted     (halted),
    .illegal_op (illegal_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic obs_t cur_obs();
    return {rf_write, mem_write, mem_sel, imm_sel, halted, illegal_op,
            alu_sel, rd_addr, rs_addr, rt_addr, imm_data, instr_addr};
  endfunction

  function automatic obs_t mk(input bit rf, input bit mw, input bit ms,
                              input bit is, input bit h, input bit il,
                              input logic [3:0] alu, input logic [2:0] rd,
                              input logic [2:0] rs, input logic [2:0] rt,
                              input logic [15:0] imm, input logic [7:0] pc);
    return {rf, mw, ms, is, h, il, alu, rd, rs, rt, imm, pc};
  endfunction

  // Leaves the bench at a falling edge with reset low: cycle 1 (FETCH).
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, exp_v;
    imem[0] = 16'h2205;
    sb.push_back('0);
    @(negedge clock);
    got = cur_obs(); exp_v = sb.pop_front(); vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL reset_hold: got %h, expected %h", got, exp_v);
    end
    reset = 1'b0;
    sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h00));
    sb.push_back(mk(0,0,0,1,0,0,4'h0,3'd1,3'd0,3'd0,16'h0005,8'h01));
    sb.push_back(mk(1,0,0,1,0,0,4'h0,3'd1,3'd0,3'd0,16'h0005,8'h01));
    for (int c = 1; c <= 3; c++) begin
      got = cur_obs(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL reset_first_fetch cycle %0d: got %h, expected %h", c, got, exp_v);
      end
      if (c < 3) @(negedge clock);
    end
    // Abort the write in flight with an asynchronous reset mid-cycle.
    #2 reset = 1'b1;
    sb.push_back('0);
    #1;
    got = cur_obs(); exp_v = sb.pop_front(); vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL reset_abort_write: got %h, expected %h", got, exp_v);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_addi_alu();
    obs_t got, exp_v;
    imem[0] = 16'h2205;
    imem[1] = 16'h1448;
    do_reset();
    sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h00));
    sb.push_back(mk(0,0,0,1,0,0,4'h0,3'd1,3'd0,3'd0,16'h0005,8'h01));
    sb.push_back(mk(1,0,0,1,0,0,4'h0,3'd1,3'd0,3'd0,16'h0005,8'h01));
    sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h01));
    sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd2,3'd1,3'd1,16'h0000,8'h02));
    sb.push_back(mk(1,0,0,0,0,0,4'h0,3'd2,3'd1,3'd1,16'h0000,8'h02));
    sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h02));
    for (int c = 1; c <= 7; c++) begin
      got = cur_obs(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL addi_alu cycle %0d: got %h, expected %h", c, got, exp_v);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_st_ld();
    obs_t got, exp_v;
    obs_t ld_v;
    imem[0] = 16'h4083;
    imem[1] = 16'h3603;
    do_reset();
    ld_v = mk(0,0,0,1,0,0,4'h0,3'd3,3'd0,3'd0,16'h0003,8'h02);
    sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h00));
    sb.push_back(mk(0,0,0,1,0,0,4'h8,3'd0,3'd2,3'd0,16'h0003,8'h01));
    sb.push_back(mk(0,1,0,1,0,0,4'h8,3'd0,3'd2,3'd0,16'h0003,8'h01));
    sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h01));
    sb.push_back(ld_v);
    sb.push_back(ld_v);
    sb.push_back(ld_v);
    sb.push_back(mk(1,0,1,1,0,0,4'h0,3'd3,3'd0,3'd0,16'h0003,8'h02));
    sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h02));
    for (int c = 1; c <= 9; c++) begin
      got = cur_obs(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL st_ld cycle %0d: got %h, expected %h", c, got, exp_v);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_branch();
    obs_t got, exp_v;
    obs_t z;
    // Taken BZ (-3), untaken BP (pos_flag low), taken BEQ (-5).
    imem[8'h00] = 16'h8010;
    imem[8'h10] = 16'h51FD;
    imem[8'h0E] = 16'h6004;
    imem[8'h0F] = 16'h72BB;
    zero_flag = 1'b1;
    pos_flag  = 1'b0;
    do_reset();
    z = '0;
    sb.push_back(z | 43'h00);
    sb.push_back(z | 43'h01);
    sb.push_back(z | 43'h01);
    sb.push_back(z | 43'h10);
    sb.push_back(mk(0,0,0,1,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h11));
    sb.push_back(mk(0,0,0,1,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h11));
    sb.push_back(z | 43'h0E);
    sb.push_back(mk(0,0,0,1,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h0F));
    sb.push_back(mk(0,0,0,1,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h0F));
    sb.push_back(z | 43'h0F);
    sb.push_back(mk(0,0,0,0,0,0,4'h1,3'd0,3'd1,3'd2,16'h0000,8'h10));
    sb.push_back(mk(0,0,0,0,0,0,4'h1,3'd0,3'd1,3'd2,16'h0000,8'h10));
    sb.push_back(z | 43'h0B);
    for (int c = 1; c <= 13; c++) begin
      got = cur_obs(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL branch_taken cycle %0d: got %h, expected %h", c, got, exp_v);
      end
      @(negedge clock);
    end
    // Same BZ with a nonzero register: falls through.
    imem[8'h10] = 16'h53FD;
    zero_flag = 1'b0;
    do_reset();
    sb.push_back(z | 43'h00);
    sb.push_back(z | 43'h01);
    sb.push_back(z | 43'h01);
    sb.push_back(z | 43'h10);
    sb.push_back(mk(0,0,0,1,0,0,4'h0,3'd0,3'd1,3'd0,16'h0000,8'h11));
    sb.push_back(mk(0,0,0,1,0,0,4'h0,3'd0,3'd1,3'd0,16'h0000,8'h11));
    sb.push_back(z | 43'h11);
    for (int c = 1; c <= 7; c++) begin
      got = cur_obs(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL branch_not_taken cycle %0d: got %h, expected %h", c, got, exp_v);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_jmp_illegal();
    obs_t got, exp_v;
    imem[8'h00] = 16'h80FF;
    imem[8'hFF] = 16'hA000;
    do_reset();
    sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h00));
    sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h01));
    sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h01));
    sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'hFF));
    sb.push_back(mk(0,0,0,0,0,1,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h00));
    sb.push_back(mk(0,0,0,0,0,1,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h00));
    sb.push_back(mk(0,0,0,0,0,1,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h00));
    sb.push_back(mk(0,0,0,0,0,1,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h01));
    for (int c = 1; c <= 8; c++) begin
      got = cur_obs(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL jmp_illegal cycle %0d: got %h, expected %h", c, got, exp_v);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_halt_and_ld_reset();
    obs_t got, exp_v;
    imem[0] = 16'hF000;
    do_reset();
    sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h00));
    sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h01));
    sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h01));
    for (int i = 0; i < 20; i++) begin
      sb.push_back(mk(0,0,0,0,1,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h01));
    end
    for (int c = 1; c <= 23; c++) begin
      got = cur_obs(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL halt cycle %0d: got %h, expected %h", c, got, exp_v);
      end
      @(negedge clock);
    end
    // Load interrupted by reset while in MEM.
    imem[0] = 16'h3603;
    do_reset();
    sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h00));
    sb.push_back(mk(0,0,0,1,0,0,4'h0,3'd3,3'd0,3'd0,16'h0003,8'h01));
    sb.push_back(mk(0,0,0,1,0,0,4'h0,3'd3,3'd0,3'd0,16'h0003,8'h01));
    sb.push_back(mk(0,0,0,1,0,0,4'h0,3'd3,3'd0,3'd0,16'h0003,8'h01));
    for (int c = 1; c <= 4; c++) begin
      got = cur_obs(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL ld_pre_reset cycle %0d: got %h, expected %h", c, got, exp_v);
      end
      if (c < 4) @(negedge clock);
    end
    #2 reset = 1'b1;
    sb.push_back('0);
    sb.push_back('0);
    #1;
    got = cur_obs(); exp_v = sb.pop_front(); vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL ld_reset_immediate: got %h, expected %h", got, exp_v);
    end
    @(posedge clock);
    #1;
    got = cur_obs(); exp_v = sb.pop_front(); vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL ld_reset_no_wb: got %h, expected %h", got, exp_v);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

`ifdef CONTROL_STEP_EN
  task automatic test_step();
    obs_t got, exp_v;
    imem[0] = 16'h2205;
    step = 1'b0;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h00));
    end
    for (int c = 1; c <= 11; c++) begin
      got = cur_obs(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL step_hold cycle %0d: got %h, expected %h", c, got, exp_v);
      end
      if (c == 11) step = 1'b1;
      @(negedge clock);
      step = 1'b0;
    end
    sb.push_back(mk(0,0,0,1,0,0,4'h0,3'd1,3'd0,3'd0,16'h0005,8'h01));
    sb.push_back(mk(1,0,0,1,0,0,4'h0,3'd1,3'd0,3'd0,16'h0005,8'h01));
    for (int i = 0; i < 8; i++) begin
      sb.push_back(mk(0,0,0,0,0,0,4'h0,3'd0,3'd0,3'd0,16'h0000,8'h01));
    end
    for (int c = 1; c <= 10; c++) begin
      got = cur_obs(); exp_v = sb.pop_front(); vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL step_single cycle %0d: got %h, expected %h", c, got, exp_v);
      end
      @(negedge clock);
    end
    step = 1'b1;
  endtask
`endif

  initial begin
    reset     = 1'b1;
    zero_flag = 1'b0;
    pos_flag  = 1'b0;
`ifdef CONTROL_STEP_EN
    step      = 1'b1;
`endif
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;

    test_reset();
    test_addi_alu();
    test_st_ld();
    test_branch();
    test_jmp_illegal();
    test_halt_and_ld_reset();
`ifdef CONTROL_STEP_EN
    test_step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
- REQ-001 The block SHALL have parameter `ALU_ADD`, default 4'h0, meaning the alu_sel code for addition.
- REQ-002 The block SHALL have parameter `ALU_SUB`, default 4'h1, meaning the alu_sel code for subtraction.
- REQ-003 The block SHALL have parameter `ALU_PASSB`, default 4'h8, meaning the alu_sel code that outputs in1 unchanged.
- REQ-004 The block SHALL have a single clock and an asynchronous, active-high reset.
- REQ-005 The block SHALL have these ports:
  - clock  input  1  system clock, rising edge
  - reset  input  1  asynchronous, active-high reset
  - instr_addr  output  8  instruction memory address (= pc)
  - instr_data  input  16  instruction word, combinational read of instr_addr
  - zero_flag  input  1  datapath flag: alu_out == 0
  - pos_flag  input  1  datapath flag: alu_out[15] == 0
  - rf_write  output  1  register file write enable
  - rs_addr, rt_addr, rd_addr  output  3 each  register addresses
  - imm_data  output  16  sign-extended immediate
  - alu_sel  output  4  ALU operation
  - imm_sel  output  1  1 = ALU in1 takes imm_data
  - mem_write  output  1  data memory write enable
  - mem_sel  output  1  1 = register file data comes from memory
  - halted  output  1  processor stopped
  - illegal_op  output  1  sticky flag: an undefined opcode was fetched

Function
- REQ-006 Instruction fields SHALL be: op = [15:12], rd = [11:9], rs = [8:6], rt = [5:3], func = [2:0], imm6 = [5:0], B-type rs = [11:9], B-type off9 = [8:0], J-type target = [7:0].
- REQ-007 Opcodes SHALL be:
  - 0 NOP
  - 1 ALU: rd = rs op rt, alu_sel = {0, func}
  - 2 ADDI: rd = rs + sext(imm6)
  - 3 LD: rd = mem[rs + sext(imm6)]
  - 4 ST: mem[imm6[4:0]] = rs, using ALU_PASSB with imm_sel = 1
  - 5 BZ, 6 BP, 7 BEQ (BEQ: rs = [11:9], rt = [8:6], off = sext([5:0]))
  - 8 JMP: pc = target
  - F HALT
  - 9–E illegal
- REQ-008 The FSM SHALL have these states: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- REQ-009 In FETCH, the block SHALL load IR <= instr_data and pc <= pc + 1 (8-bit wrap, FF -> 00), then go to DECODE.
- REQ-010 In DECODE, the block SHALL drive the address, imm and select fields from IR with all write enables at 0, then go to EXECUTE.
- REQ-011 In EXECUTE for ALU/ADDI, the block SHALL assert rf_write for exactly this cycle with mem_sel = 0, then go to FETCH (CPI = 3).
- REQ-012 In EXECUTE for ST, the block SHALL assert mem_write for exactly this cycle, then go to FETCH.
- REQ-013 For LD, the sequence SHALL be EXECUTE -> MEM -> WB (CPI = 5):
  - EXECUTE and MEM drive ALU_ADD with imm_sel = 1 and no write.
  - WB asserts rf_write with mem_sel = 1.
  - rs_addr, imm_data and alu_sel are held stable across EXECUTE, MEM and WB.
- REQ-014 Branches SHALL be resolved in EXECUTE by sampling the flags combinationally:
  - BZ/BP drive ALU_ADD with imm_sel = 1 and imm_data = 0.
  - BEQ drives ALU_SUB with imm_sel = 0.
  - If taken (BZ: zero_flag; BP: pos_flag; BEQ: zero_flag), pc <= pc + sext(off), where pc is already incremented; offset arithmetic is 8-bit modulo.
- REQ-015 JMP SHALL set pc <= target in EXECUTE.
- REQ-016 HALT SHALL enter the HALT state, which is absorbing; halted = 1 there and all write enables are 0.
- REQ-017 An illegal opcode SHALL set illegal_op = 1 (held until reset), execute as NOP, and then go to FETCH.
- REQ-018 rf_write and mem_write SHALL never both be 1, and neither SHALL be 1 in FETCH or DECODE.
- REQ-019 Outputs SHALL be a pure function of state and IR (Moore), except that the branch pc update uses the live flags.

Reset
- REQ-020 Asserting reset at any time, including mid-instruction, SHALL immediately set:
  - state = FETCH, pc = 0, IR = 0
  - rf_write = 0, mem_write = 0
  - halted = 0, illegal_op = 0
  - all address, immediate and select outputs = 0
- REQ-021 A write in progress SHALL be aborted by reset, with no partial cycle.
- REQ-022 The first fetch SHALL occur on the first rising edge after reset deasserts.

Configuration
- REQ-023 When CONTROL_STEP_EN is defined, the block SHALL add input port `step` (1 bit) and stay in FETCH (IR and pc unchanged) until step = 1 is sampled on a rising edge; behaviour is otherwise unchanged.
- REQ-024 When CONTROL_STEP_EN is undefined, `step` SHALL be absent and FETCH SHALL always advance after one cycle.

Verification
- REQ-025 The bench SHALL cover these directed scenarios:
  - ADDI r1, r0, 5, then ALU r2 = r1 + r1 (func 0) -> rf_write pulses at cycles 3 and 6, rd_addr 1 then 2, imm_data 0x0005.
  - ST r2 to address 3, then LD r3 from (r0 + 3) -> one mem_write pulse with alu_sel = 8; LD asserts rf_write with mem_sel = 1 only in WB (5th cycle).
  - BZ with rs = 0 and off = -3 at pc 0x10 -> pc becomes 0x0E; with the rs value nonzero -> pc becomes 0x11.
  - JMP 0xFF, then fetch -> pc wraps to 0x00; opcode 0xA -> illegal_op = 1, no write, execution continues.
  - HALT -> halted = 1 for 20 cycles with instr_addr frozen; reset asserted mid-LD in MEM -> immediate pc = 0, no rf_write.
  - With CONTROL_STEP_EN defined: hold step = 0 for 10 cycles -> IR and pc unchanged; a single step pulse -> exactly one instruction completes.
